axi_lite_regfile: RTL and testbench
===================================

# axi_lite_regfile

Parametrised AXI-Lite slave register bank: NUM_REGS registers of DATA_WIDTH bits, written and read through one AXI-Lite port with byte strobes and an out-of-range policy. It sits behind the shell's AXI-Lite management path (OCL/BAR1) and drives control registers into the CL datapath. A one-cycle write pulse per register lets downstream logic act on writes.

## Interface
- ADDR_WIDTH, 32, AXI-Lite address width.
- DATA_WIDTH, 32, data width; legal values 32 or 64.
- NUM_REGS, 16, number of registers; 1..256.
- RESET_VAL, 0, reset value of every register (DATA_WIDTH bits).
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- awaddr, awvalid  in  ADDR_WIDTH, 1; awready  out  1.
- wdata, wstrb, wvalid  in  DATA_WIDTH, DATA_WIDTH/8, 1; wready  out  1.
- bresp, bvalid  out  2, 1; bready  in  1.
- araddr, arvalid  in  ADDR_WIDTH, 1; arready  out  1.
- rdata, rresp, rvalid  out  DATA_WIDTH, 2, 1; rready  in  1.
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  one-cycle strobe, bit i set in the cycle after register i is written.

## Operation
- Decode: OFF = log2(DATA_WIDTH/8); index = addr[ADDR_WIDTH-1:OFF]; in range iff index < NUM_REGS. Address bits below OFF ignored.
- Write channel: independent holding flags aw_held, w_held. awready = !aw_held && !bvalid; wready = !w_held && !bvalid. AW and W may arrive in either order or the same cycle.
- Commit: at the edge where address and data are both available (held or handshaking that edge), byte lane k of the indexed register loads wdata lane k iff wstrb[k]; flags clear; bvalid sets; bresp set per Configuration. wstrb = 0 commits no bytes but still responds and pulses wr_pulse.
- bvalid held, bresp stable, until bvalid && bready; no new AW/W accepted while bvalid.
- Read: arready = !rvalid. On AR handshake, rdata/rresp register at that edge; rvalid held with stable data until rvalid && rready.
- Read and write commit to the same register at the same edge: read returns the pre-write value.
- Out-of-range write: no register modified, no wr_pulse.

## Timing
- Reset values: awready 1, wready 1, arready 1, bvalid 0, bresp 0, rvalid 0, rresp 0, rdata 0, reg_q all RESET_VAL, wr_pulse 0, holding flags 0.
- Write latency: AW+W handshake at edge N → reg_q updated, bvalid = 1, wr_pulse[i] = 1 after edge N; wr_pulse cleared after edge N+1.
- Read latency: AR handshake at edge N → rvalid = 1 after edge N. Throughput one read per two cycles with rready tied high; same for writes.
- Reset mid-transaction: all state, including pending bvalid/rvalid and holding flags, returns to reset values immediately; partially received transactions are discarded.

## Configuration
- AXIL_REGFILE_SLVERR_EN defined: out-of-range write gives bresp = 2'b10 (SLVERR); out-of-range read gives rresp = 2'b10, rdata = 0.
- Undefined: all responses OKAY (2'b00); out-of-range reads return rdata = 0, writes silently dropped.
- In-range accesses always OKAY.

## Test plan
- Reset: assert rst_n low mid-write with aw_held set → after release reg_q = RESET_VAL, bvalid = 0, awready = wready = 1.
- AW at cycle 0, W at cycle 3, addr 0x8, wdata 0xDEADBEEF, wstrb 0xF → reg 2 = 0xDEADBEEF, bvalid after W edge, wr_pulse[2] high exactly one cycle.
- Partial strobe: reg 1 = 0x11223344, write 0xAABBCCDD wstrb 0x5 → reg 1 = 0x11BB33DD; read 0x4 returns 0x11BB33DD, rresp 0.
- Backpressure: bready low 5 cycles → bvalid/bresp stable, awready = wready = 0; rready low 5 cycles → rdata stable.
- Simultaneous read and write to reg 3 (old 0x0, new 0x5) → rdata 0x0, subsequent read 0x5.
- Address 0x40 with NUM_REGS = 16: with macro bresp/rresp = 2'b10, rdata 0; without macro 2'b00, rdata 0; no reg_q change either way.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register bank with byte strobes and per-register write pulses.
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = ADDR_WIDTH - OFF;
  localparam int RW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW:0] NREG = (IW+1)'(NUM_REGS);
  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdat;
  logic [NB-1:0]         wstb;
  logic [IW-1:0]         widx;
  logic [IW-1:0]         ridx;
  logic                  w_in;
  logic                  r_in;
  logic [RW-1:0]         wsel;
  logic [RW-1:0]         rsel;
  logic                  unused_lsb;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // Address and data may each come from the holding register or the bus.
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  always_comb begin
    waddr = awaddr;
    wdat  = wdata;
    wstb  = wstrb;
    if (aw_held) waddr = awaddr_q;
    if (w_held) begin
      wdat = wdata_q;
      wstb = wstrb_q;
    end
  end

  assign widx = waddr[ADDR_WIDTH-1:OFF];
  assign ridx = araddr[ADDR_WIDTH-1:OFF];
  assign w_in = {1'b0, widx} < NREG;
  assign r_in = {1'b0, ridx} < NREG;
  assign wsel = widx[RW-1:0];
  assign rsel = ridx[RW-1:0];

  assign unused_lsb = ^{waddr[OFF-1:0], araddr[OFF-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VAL;
    end else if (commit && w_in) begin
      for (int k = 0; k < NB; k++)
        if (wstb[k])
          regs[wsel][k*8 +: 8] <= wdat[k*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit && w_in)
        wr_pulse[wsel] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid <= 1'b0;
      bresp  <= OKAY;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= w_in ? OKAY : ERR;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end
  end

  // Reads sample the array before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rresp  <= OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= r_in ? OKAY : ERR;
      rdata  <= r_in ? regs[rsel] : '0;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed testbench for axi_lite_regfile (16 x 32-bit registers).
// Expected out-of-range responses follow AXIL_REGFILE_SLVERR_EN.
module tb_axi_lite_regfile;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [511:0] reg_q;
  logic [15:0]  wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  axi_lite_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  function automatic logic [511:0] packed_model();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp,
                           output logic [15:0] pulse);
    int n;
    logic ah, wh;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      ah = awready; wh = wready;
      tick();
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    resp = bresp; pulse = wr_pulse;
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h got bvalid=0 required 1", a);
    end
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    logic h;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      h = arready; tick();
      if (h) arvalid = 1'b0;
      n++;
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    d = rdata; resp = rresp;
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h got rvalid=0 required 1", a);
    end
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL async_reset_ready got %b required 111",
               {awready, wready, arready});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    tick();
  endtask

  task automatic test_reset();
    logic [1:0] r;
    logic [15:0] p;
    rst_n = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arvalid = 0; rready = 0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({awready, wready, arready, bvalid, bresp, rvalid, rresp}
        !== 9'b111_0_00_0_00) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 111000000",
               {awready, wready, arready, bvalid, bresp, rvalid, rresp});
    end
    checks++;
    if (rdata !== 32'h0 || wr_pulse !== 16'h0) begin
      errors++;
      $display("FAIL reset_out got rdata=%h pulse=%h required 0 0",
               rdata, wr_pulse);
    end
    checks++;
    if (reg_q !== 512'h0) begin
      errors++;
      $display("FAIL reset_regq got %h required 0", reg_q);
    end
    axi_write(32'h14, 32'h1234, 4'hF, r, p);
    checks++;
    if (reg_q[5*32 +: 32] !== 32'h1234) begin
      errors++;
      $display("FAIL pre_reset_reg5 got %h required 00001234",
               reg_q[5*32 +: 32]);
    end
    awaddr = 32'h18; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b010) begin
      errors++;
      $display("FAIL aw_held got %b required 010",
               {awready, wready, bvalid});
    end
    do_reset();
    checks++;
    if (reg_q !== 512'h0 || {bvalid, awready, wready} !== 3'b011) begin
      errors++;
      $display("FAIL midwrite_reset got b/aw/w=%b reg5=%h required 011 0",
               {bvalid, awready, wready}, reg_q[5*32 +: 32]);
    end
    wdata = 32'hFFFF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    checks++;
    if ({bvalid, wready, awready} !== 3'b001 || reg_q !== 512'h0) begin
      errors++;
      $display("FAIL flag_discard got b/w/aw=%b required 001", 
               {bvalid, wready, awready});
    end
    do_reset();
  endtask

  task automatic test_aw_then_w();
    awaddr = 32'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick(); tick();
    checks++;
    if ({bvalid, awready, wready} !== 3'b001) begin
      errors++;
      $display("FAIL aw_wait got b/aw/w=%b required 001",
               {bvalid, awready, wready});
    end
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    model[2] = 32'hDEADBEEF;
    checks++;
    if ({bvalid, bresp} !== 3'b100 || wr_pulse !== 16'h0004) begin
      errors++;
      $display("FAIL w_commit got b=%b resp=%b pulse=%h required 1 00 0004",
               bvalid, bresp, wr_pulse);
    end
    checks++;
    if (reg_q !== packed_model()) begin
      errors++;
      $display("FAIL reg2_value got %h required deadbeef",
               reg_q[2*32 +: 32]);
    end
    tick();
    checks++;
    if (wr_pulse !== 16'h0 || bvalid !== 1'b1) begin
      errors++;
      $display("FAIL pulse_one_cycle got pulse=%h b=%b required 0000 1",
               wr_pulse, bvalid);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++;
      $display("FAIL b_accept got b/aw/w=%b required 011",
               {bvalid, awready, wready});
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r;
    logic [15:0] p;
    logic [31:0] d;
    axi_write(32'h4, 32'h11223344, 4'hF, r, p);
    axi_write(32'h4, 32'hAABBCCDD, 4'h5, r, p);
    model[1] = 32'h11BB33DD;
    checks++;
    if (r !== 2'b00 || p !== 16'h0002) begin
      errors++;
      $display("FAIL strobe_resp got resp=%b pulse=%h required 00 0002", r, p);
    end
    checks++;
    if (reg_q !== packed_model()) begin
      errors++;
      $display("FAIL strobe_reg1 got %h required 11bb33dd",
               reg_q[1*32 +: 32]);
    end
    axi_read(32'h4, d, r);
    checks++;
    if (d !== 32'h11BB33DD || r !== 2'b00) begin
      errors++;
      $display("FAIL strobe_read got %h/%b required 11bb33dd/00", d, r);
    end
    axi_write(32'h4, 32'hFFFFFFFF, 4'h0, r, p);
    checks++;
    if (r !== 2'b00 || p !== 16'h0002 || reg_q !== packed_model()) begin
      errors++;
      $display("FAIL zero_strobe got resp=%b pulse=%h reg1=%h required 00 0002 11bb33dd",
               r, p, reg_q[1*32 +: 32]);
    end
  endtask

  task automatic test_backpressure();
    awaddr = 32'h10; wdata = 32'hCAFE; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    model[4] = 32'hCAFE;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
        errors++;
        $display("FAIL b_hold cycle %0d got %b required 10000", i,
                 {bvalid, bresp, awready, wready});
      end
      tick();
    end
    bready = 1'b1; tick(); bready = 1'b0;
    araddr = 32'h10; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid, rresp, arready} !== 4'b1000 || rdata !== 32'hCAFE) begin
        errors++;
        $display("FAIL r_hold cycle %0d got v/resp/ar=%b data=%h required 1000 0000cafe",
                 i, {rvalid, rresp, arready}, rdata);
      end
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++;
      $display("FAIL r_accept got %b required 01", {rvalid, arready});
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] d;
    logic [1:0] r;
    awaddr = 32'hC; wdata = 32'h5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'hC; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[3] = 32'h5;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0 || reg_q !== packed_model()) begin
      errors++;
      $display("FAIL same_edge got rv=%b rdata=%h reg3=%h required 1 0 5",
               rvalid, rdata, reg_q[3*32 +: 32]);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(32'hC, d, r);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL same_edge_after got %h required 5", d);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] d;
    logic [1:0] r;
    logic [15:0] p;
    axi_write(32'h3C, 32'h0F0F0F0F, 4'hF, r, p);
    model[15] = 32'h0F0F0F0F;
    checks++;
    if (r !== 2'b00 || p !== 16'h8000 || reg_q !== packed_model()) begin
      errors++;
      $display("FAIL last_reg got resp=%b pulse=%h reg15=%h required 00 8000 0f0f0f0f",
               r, p, reg_q[15*32 +: 32]);
    end
    axi_read(32'hE, d, r);
    checks++;
    if (d !== 32'h5 || r !== 2'b00) begin
      errors++;
      $display("FAIL low_bits_ignored got %h/%b required 5/00", d, r);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0] r;
    logic [15:0] p;
    axi_write(32'h40, 32'h12345678, 4'hF, r, p);
    checks++;
    if (r !== EXP_ERR || p !== 16'h0) begin
      errors++;
      $display("FAIL oor_write got resp=%b pulse=%h required %b 0000",
               r, p, EXP_ERR);
    end
    checks++;
    if (reg_q !== packed_model()) begin
      errors++;
      $display("FAIL oor_regq got reg0=%h required %h",
               reg_q[31:0], model[0]);
    end
    axi_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== EXP_ERR) begin
      errors++;
      $display("FAIL oor_read got %h/%b required 0/%b", d, r, EXP_ERR);
    end
    axi_read(32'h0, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++;
      $display("FAIL inrange_after got %h/%b required 0/00", d, r);
    end
  endtask

  initial begin
    test_reset();
    test_aw_then_w();
    test_strobe();
    test_backpressure();
    test_same_edge();
    test_boundary();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
